// File: rtl/coin_front_end.sv
// -----------------------------------------------------------------------------
// coin_front_end
//
// Conditions the two raw coin sensors ahead of the vending FSM. Each sensor is
// synchronised, debounced and edge-detected. Detected coins are queued in a
// small FIFO and issued one at a time as a single-cycle coin_type code:
// 00 none, 01 50 won, 10 100 won. At least GAP_CYCLES idle cycles separate
// two issued coins. A coin that finds no free slot is dropped and reported
// on reject/reject_type so the mechanism can return it.
//
// Ports
//   clk          system clock
//   rst          asynchronous, active-low reset
//   coin50_raw   raw 50-won sensor (asynchronous, may bounce)
//   coin100_raw  raw 100-won sensor (asynchronous, may bounce)
//   accept_en    downstream can take a coin this cycle
//   coin_type    issued coin code, registered, nonzero for one cycle per coin
//   reject       one-cycle pulse when a detected coin was dropped
//   reject_type  code of the dropped coin while reject=1, else 00
//   pending      current queue occupancy
// -----------------------------------------------------------------------------
module coin_front_end #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int GAP_CYCLES      = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          coin50_raw,
  input  logic                          coin100_raw,
  input  logic                          accept_en,
  output logic [1:0]                    coin_type,
  output logic                          reject,
  output logic [1:0]                    reject_type,
  output logic [$clog2(FIFO_DEPTH):0]   pending
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [3:0]    DEB_LAST = 4'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [2:0]    GAP_C    = 3'(GAP_CYCLES);

  // Channel index 0 is the 50-won sensor, index 1 the 100-won sensor.
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    deb;
  logic [1:0]    deb_q;
  logic [3:0]    cnt [2];

  logic [1:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [2:0]    gap;

  logic [1:0]    evt;
  logic [CW-1:0] free_slots;
  logic          push50;
  logic          push100;
  logic          rej50;
  logic          rej100;
  logic          pop;

  // ---- Stage: two-flop synchroniser, debounce and level history ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1  <= 2'b00;
      sync2  <= 2'b00;
      deb    <= 2'b00;
      deb_q  <= 2'b00;
      cnt[0] <= 4'd0;
      cnt[1] <= 4'd0;
    end else begin
      sync1 <= {coin100_raw, coin50_raw};
      sync2 <= sync1;
      deb_q <= deb;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= 4'd0;
        end else if (cnt[i] == DEB_LAST) begin
          deb[i] <= ~deb[i];
          cnt[i] <= 4'd0;
        end else begin
          cnt[i] <= cnt[i] + 4'd1;
        end
      end
    end
  end

  // ---- Stage: coin detection and enqueue/issue decisions ----
  // Free space is taken from the occupancy before any pop this cycle, so a
  // coin arriving while the queue is full is dropped even if the head leaves.
  always_comb begin
    evt        = deb & ~deb_q;
    free_slots = DEPTH_C - count;
    push50     = evt[0] && (free_slots != '0);
    // When both channels fire, the 50-won coin takes the first free slot.
    push100    = evt[1] && (evt[0] ? (free_slots >= CW'(2)) : (free_slots != '0));
    rej50      = evt[0] && !push50;
    rej100     = evt[1] && !push100;
    pop        = (count != '0) && accept_en && (gap == 3'd0);
  end

  // Queue storage carries data only; occupancy and pointers guard every read.
  always_ff @(posedge clk) begin
    if (push50) begin
      mem[wr_ptr] <= 2'b01;
    end
    if (push100) begin
      mem[wr_ptr + PW'(push50)] <= 2'b10;
    end
  end

  // ---- Stage: queue control, issue spacing and registered outputs ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      gap         <= 3'd0;
      coin_type   <= 2'b00;
      reject      <= 1'b0;
      reject_type <= 2'b00;
    end else begin
      wr_ptr <= wr_ptr + PW'(push50) + PW'(push100);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + CW'(push50) + CW'(push100) - CW'(pop);

      if (pop) begin
        gap <= GAP_C;
      end else if (gap != 3'd0) begin
        gap <= gap - 3'd1;
      end

      coin_type <= pop ? mem[rd_ptr] : 2'b00;

      // A double drop is a single pulse reporting the 100-won code.
      reject      <= rej50 | rej100;
      reject_type <= rej100 ? 2'b10 : (rej50 ? 2'b01 : 2'b00);
    end
  end

  assign pending = count;

endmodule

// File: tb/tb_coin_front_end.sv
`timescale 1ns/1ps
// Randomised and directed bench for coin_front_end with a scoreboard fed by
// a behavioural reference model (debounce by stable-sample window, queue as
// an SV queue, issue spacing by edge index of the last issue).
module tb_coin_front_end;

  localparam int D     = 4;
  localparam int DEPTH = 4;
  localparam int GAP   = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       coin50_raw = 1'b0;
  logic       coin100_raw = 1'b0;
  logic       accept_en = 1'b0;
  logic [1:0] coin_type;
  logic       reject;
  logic [1:0] reject_type;
  logic [2:0] pending;

  coin_front_end #(
    .DEBOUNCE_CYCLES(D),
    .FIFO_DEPTH     (DEPTH),
    .GAP_CYCLES     (GAP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .coin50_raw (coin50_raw),
    .coin100_raw(coin100_raw),
    .accept_en  (accept_en),
    .coin_type  (coin_type),
    .reject     (reject),
    .reject_type(reject_type),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    int code;
    int cyc;
  } exp_t;

  exp_t sb_coin[$];
  exp_t sb_rej[$];

  int edge_cnt = 0;
  int errors   = 0;
  int checks   = 0;

  // Reference model state
  int m_q[$];
  bit m_d1[2];
  bit m_d2[2];
  bit m_deb[2];
  bit m_evt[2];
  bit m_win[2][$];
  int m_last_issue = -1000;
  int m_occ = 0;

  // Requests from the stimulus process to the monitor for off-edge checks
  int   req_id = 0;
  int   seen_id = 0;
  int   req_kind = 0;
  event chk_ev;

  always @(posedge clk or negedge rst) begin
    int  occ_pre;
    int  free;
    int  code;
    bit  rej50;
    bit  rej100;
    bit  raw[2];
    bit  s2;
    bit  all_diff;
    if (!rst) begin
      m_q.delete();
      sb_coin.delete();
      sb_rej.delete();
      for (int c = 0; c < 2; c++) begin
        m_d1[c]  = 1'b0;
        m_d2[c]  = 1'b0;
        m_deb[c] = 1'b0;
        m_evt[c] = 1'b0;
        m_win[c].delete();
      end
      m_last_issue = -1000;
      m_occ = 0;
    end else begin
      edge_cnt++;
      raw[0]  = coin50_raw;
      raw[1]  = coin100_raw;
      occ_pre = m_q.size();

      // Issue: oldest coin leaves once the spacing since the last issue allows
      if (occ_pre > 0 && accept_en && (edge_cnt - m_last_issue > GAP)) begin
        code = m_q.pop_front();
        sb_coin.push_back('{code, edge_cnt});
        m_last_issue = edge_cnt;
      end

      // Enqueue coins detected one edge earlier; space counted before the pop
      free   = DEPTH - occ_pre;
      rej50  = 1'b0;
      rej100 = 1'b0;
      if (m_evt[0]) begin
        if (free > 0) begin
          m_q.push_back(1);
          free--;
        end else begin
          rej50 = 1'b1;
        end
      end
      if (m_evt[1]) begin
        if (free > 0) begin
          m_q.push_back(2);
          free--;
        end else begin
          rej100 = 1'b1;
        end
      end
      if (rej50 || rej100) sb_rej.push_back('{(rej100 ? 2 : 1), edge_cnt});
      m_occ = m_q.size();

      // Debounce: level flips once the last D synchronised samples all disagree
      for (int c = 0; c < 2; c++) begin
        s2      = m_d2[c];
        m_d2[c] = m_d1[c];
        m_d1[c] = raw[c];
        m_win[c].push_back(s2);
        if (m_win[c].size() > D) void'(m_win[c].pop_front());
        m_evt[c] = 1'b0;
        if (m_win[c].size() == D) begin
          all_diff = 1'b1;
          foreach (m_win[c][k]) if (m_win[c][k] == m_deb[c]) all_diff = 1'b0;
          if (all_diff) begin
            m_deb[c] = ~m_deb[c];
            m_evt[c] = m_deb[c];
          end
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d, t=%0t)", name, act, exp, edge_cnt, $time);
    end
  endtask

  // Monitor / scoreboard consumer
  always begin
    exp_t e;
    int   exp_c;
    int   exp_r;
    @(negedge clk or chk_ev);
    if (req_id != seen_id) begin
      seen_id = req_id;
      if (req_kind == 0) begin
        check("rst_coin_type",   int'(coin_type),   0);
        check("rst_pending",     int'(pending),     0);
        check("rst_reject",      int'(reject),      0);
        check("rst_reject_type", int'(reject_type), 0);
      end else begin
        check("coins_outstanding",   sb_coin.size(), 0);
        check("rejects_outstanding", sb_rej.size(),  0);
      end
    end else begin
      exp_c = 0;
      if (sb_coin.size() > 0 && sb_coin[0].cyc <= edge_cnt) begin
        e = sb_coin.pop_front();
        exp_c = e.code;
      end
      if (coin_type != 2'b00 || exp_c != 0) check("coin_type", int'(coin_type), exp_c);

      exp_r = 0;
      if (sb_rej.size() > 0 && sb_rej[0].cyc <= edge_cnt) begin
        e = sb_rej.pop_front();
        exp_r = e.code;
      end
      if (reject || exp_r != 0) check("reject", int'(reject), (exp_r != 0) ? 1 : 0);
      check("reject_type", int'(reject_type), exp_r);
      check("pending", int'(pending), m_occ);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse50(input int hi, input int lo);
    coin50_raw = 1'b1;
    idle(hi);
    coin50_raw = 1'b0;
    idle(lo);
  endtask

  task automatic request(input int kind);
    req_kind = kind;
    req_id++;
    ->chk_ev;
  endtask

  initial begin
    rst       = 1'b0;
    accept_en = 1'b1;
    idle(2);
    #3;
    request(0);
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    // Clean 50-won coin held well past the debounce window
    pulse50(10, 14);

    // Bouncy 100-won coin, then a standalone too-short pulse
    coin100_raw = 1'b1; idle(3);
    coin100_raw = 1'b0; idle(2);
    coin100_raw = 1'b1; idle(8);
    coin100_raw = 1'b0; idle(14);
    coin100_raw = 1'b1; idle(3);
    coin100_raw = 1'b0; idle(14);

    // Both sensors together
    coin50_raw = 1'b1; coin100_raw = 1'b1; idle(8);
    coin50_raw = 1'b0; coin100_raw = 1'b0; idle(14);

    // Backpressure with overflow, then drain
    accept_en = 1'b0;
    repeat (6) pulse50(6, 6);
    idle(4);
    accept_en = 1'b1;
    idle(16);

    // Full queue, new coin lands in the same cycle as a pop
    accept_en = 1'b0;
    repeat (4) pulse50(6, 6);
    coin50_raw = 1'b1;
    idle(6);
    accept_en = 1'b1;
    idle(4);
    coin50_raw = 1'b0;
    idle(20);

    // Asynchronous reset with three coins queued
    accept_en = 1'b0;
    repeat (3) pulse50(6, 6);
    idle(2);
    #2;
    rst = 1'b0;
    #1;
    request(0);
    idle(2);
    rst = 1'b1;
    accept_en = 1'b1;
    idle(20);

    // Random sensor activity with bounces and random backpressure
    for (int i = 0; i < 60; i++) begin
      accept_en   = ($urandom_range(0, 3) != 0);
      coin50_raw  = 1'($urandom_range(0, 1));
      coin100_raw = 1'($urandom_range(0, 1));
      idle($urandom_range(1, 9));
    end
    coin50_raw  = 1'b0;
    coin100_raw = 1'b0;
    accept_en   = 1'b1;
    idle(40);

    #3;
    request(1);
    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
